// File: rtl/misr_pkg.sv
// misr_pkg: shared state encoding and default MISR parameters.
// Revision 1.0
`default_nettype none

package misr_pkg;

  localparam int         MISR_WIDTH = 8;
  localparam logic [7:0] MISR_POLY  = 8'h1D;
  localparam logic [7:0] MISR_SEED  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/misr_core.sv
// misr_core: Galois-form multiple-input signature register with load and step enable.
// Revision 1.0
`default_nettype none

module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = MISR_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  // Load wins over step so a new run always begins from the seed.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/misr_sig_analyzer.sv
// misr_sig_analyzer: compacts test_len response words into a MISR and compares to a golden signature.
// Revision 1.0
`default_nettype none

module misr_sig_analyzer
  import misr_pkg::*;
#(
  parameter int               WIDTH = MISR_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(MISR_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [7:0]       test_len,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       len_q, len_d;
  logic [WIDTH-1:0] golden_q, golden_d;
  logic             pass_q, pass_d;
  logic             w_load;
  logic             w_en;
  logic [WIDTH-1:0] w_sig;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .en   (w_en),
    .seed (SEED),
    .din  (din),
    .sig  (w_sig)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    golden_d = golden_q;
    pass_d   = pass_q;
    w_load   = 1'b0;
    w_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_load   = 1'b1;
          cnt_d    = 8'd0;
          len_d    = test_len;
          golden_d = golden;
          pass_d   = 1'b0;
          state_d  = (test_len != 8'd0) ? ST_COMPACT : ST_COMPARE;
        end
      end
      ST_COMPACT: begin
        // Stalls simply hold; there is deliberately no timeout.
        if (din_valid) begin
          w_en  = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) begin
            state_d = ST_COMPARE;
          end
        end
      end
      ST_COMPARE: begin
        pass_d  = (w_sig == golden_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      len_q    <= 8'd0;
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      golden_q <= golden_d;
      pass_q   <= pass_d;
    end
  end

  // All outputs decode from registers only, so din never reaches done or pass combinationally.
  assign signature = w_sig;
  assign busy      = (state_q == ST_COMPACT) || (state_q == ST_COMPARE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_misr_sig_analyzer.sv
// tb_misr_sig_analyzer: directed and randomized runs checked against a polynomial-division reference model.
// Revision 1.0
`default_nettype none

module tb_misr_sig_analyzer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] test_len;
  logic [7:0] golden;
  logic [7:0] signature;
  logic       busy;
  logic       done;
  logic       pass;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  misr_sig_analyzer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .test_len  (test_len),
    .golden    (golden),
    .signature (signature),
    .busy      (busy),
    .done      (done),
    .pass      (pass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Multiply by x modulo x^8+x^4+x^3+x^2+1, then add the input word.
  function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] d);
    logic [8:0] v;
    v = {s, 1'b0};
    if (v[8]) v = v ^ 9'h11D;
    return v[7:0] ^ d;
  endfunction

  function automatic logic [7:0] ref_sig(input logic [7:0] words[$]);
    logic [7:0] s;
    s = 8'hFF;
    foreach (words[i]) s = ref_step(s, words[i]);
    return s;
  endfunction

  // mode 0: no stalls, 1: one stall before every word but the first, 2: random stalls and stray starts
  task automatic do_run(input logic [7:0] words[$], input logic [7:0] gold, input int mode);
    int         len;
    logic [7:0] m;
    logic [7:0] fin;
    len = words.size();
    m   = 8'hFF;
    fin = ref_sig(words);
    start     = 1'b1;
    test_len  = len[7:0];
    golden    = gold;
    din_valid = 1'($urandom % 2);
    din       = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk("pass_cleared", {31'd0, pass}, 32'd0);
    chk("busy_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < len; i++) begin
      int ns;
      ns = (mode == 1 && i > 0) ? 1 : ((mode == 2) ? int'($urandom_range(0, 2)) : 0);
      repeat (ns) begin
        din_valid = 1'b0;
        din       = 8'($urandom);
        start     = (mode == 2) && ($urandom % 2 == 0);
        test_len  = 8'($urandom);
        golden    = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        chk("busy_stall", {31'd0, busy}, 32'd1);
        chk("sig_stall", {24'd0, signature}, {24'd0, m});
      end
      din_valid = 1'b1;
      din       = words[i];
      @(negedge clk);
      din_valid = 1'b0;
      m = ref_step(m, words[i]);
      if (i < len - 1) begin
        chk("busy_compact", {31'd0, busy}, 32'd1);
        chk("sig_compact", {24'd0, signature}, {24'd0, m});
      end
    end
    // COMPARE
    chk("busy_compare", {31'd0, busy}, 32'd1);
    chk("done_compare", {31'd0, done}, 32'd0);
    chk("sig_compare", {24'd0, signature}, {24'd0, fin});
    din_valid = 1'($urandom % 2);
    din       = 8'($urandom);
    @(negedge clk);
    // DONE
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("pass_verdict", {31'd0, pass}, {31'd0, fin == gold});
    chk("sig_done", {24'd0, signature}, {24'd0, fin});
    din_valid = 1'($urandom % 2);
    din       = 8'($urandom);
    @(negedge clk);
    // back in IDLE
    chk("done_low", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("pass_held", {31'd0, pass}, {31'd0, fin == gold});
    chk("sig_held", {24'd0, signature}, {24'd0, fin});
    din_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    rst = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0; test_len = '0; golden = '0;
    repeat (2) @(negedge clk);
    chk("rst_sig", {24'd0, signature}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    q = '{8'h00};
    do_run(q, 8'hE3, 0);
    chk("single_sig", {24'd0, signature}, 32'hE3);
    chk("single_pass", {31'd0, pass}, 32'd1);

    q = '{8'h00, 8'h00};
    do_run(q, 8'hDB, 1);
    chk("stall_sig", {24'd0, signature}, 32'hDB);
    chk("stall_pass", {31'd0, pass}, 32'd1);

    do_run(q, 8'hDA, 1);
    chk("faildet_sig", {24'd0, signature}, 32'hDB);
    chk("faildet_pass", {31'd0, pass}, 32'd0);

    q = {};
    do_run(q, 8'hFF, 0);
    chk("zero_sig", {24'd0, signature}, 32'hFF);
    chk("zero_pass", {31'd0, pass}, 32'd1);

    // Abort mid-run; rst must also beat a concurrent start and din_valid.
    start = 1'b1; test_len = 8'd5; golden = 8'h00;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1; din = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b1; start = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    chk("abort_sig", {24'd0, signature}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    rst = 1'b0; start = 1'b0; din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    q = '{8'h00};
    do_run(q, 8'hE3, 0);
    chk("rerun_sig", {24'd0, signature}, 32'hE3);
    chk("rerun_pass", {31'd0, pass}, 32'd1);

    for (int r = 0; r < 20; r++) begin
      int         len;
      logic [7:0] g;
      len = $urandom_range(0, 20);
      q = {};
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      g = ref_sig(q);
      if ($urandom % 2 == 0) g = g ^ 8'(1 << $urandom_range(0, 7));
      do_run(q, g, 2);
    end

    q = {};
    for (int k = 0; k < 255; k++) q.push_back(8'($urandom));
    do_run(q, ref_sig(q), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/misr_sig_analyzer.md
MISR_SIG_ANALYZER -- requirements
Module: misr_sig_analyzer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- WIDTH, 8, data and signature width
- POLY, 8'h1D, feedback polynomial x^8+x^4+x^3+x^2+1 in Galois form
- SEED, 8'hFF, signature load value at start

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock; all logic on the rising edge
- rst, in, 1, reset: synchronous, active-high
- start, in, 1, begin a compaction run; sampled only in IDLE
- din, in, WIDTH, response word from the upstream parallel register
- din_valid, in, 1, din is valid this cycle
- test_len, in, 8, number of words to compact; sampled at start
- golden, in, WIDTH, expected signature; sampled at start
- signature, out, WIDTH, current MISR contents
- busy, out, 1, high in COMPACT and COMPARE
- done, out, 1, one-cycle pulse when the verdict is valid
- pass, out, 1, verdict; held until the next accepted start

Function
REQ-003 The FSM SHALL have the states IDLE, COMPACT, COMPARE and DONE.
REQ-004 In IDLE with start=1: signature<=SEED, cnt<=0, and test_len and golden are latched. The next state SHALL be COMPACT if test_len!=0, else COMPARE.
REQ-005 The MISR step SHALL be next = ({sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0)) ^ din.
REQ-006 In COMPACT with din_valid=1: the signature takes the step of REQ-005 and cnt increments. On the word where cnt==len-1, the next state SHALL be COMPARE.
REQ-007 In COMPACT with din_valid=0: signature and cnt SHALL hold, with no timeout.
REQ-008 In COMPARE: pass<=(signature==golden_q), then go to DONE. This state lasts exactly one cycle and ignores din_valid.
REQ-009 In DONE: done=1 for exactly one cycle, then go to IDLE. The signature SHALL hold its final value until the next start.
REQ-010 pass SHALL be cleared on an accepted start. start in any state other than IDLE SHALL be ignored.
REQ-011 din_valid outside COMPACT SHALL be ignored, and the signature SHALL be unchanged.
REQ-012 Latency from the final valid word to the done pulse SHALL be 2 cycles: COMPARE, then DONE.
REQ-013 cnt SHALL be 8 bits. test_len=255 compacts exactly 255 words with no wrap. test_len=0 compacts none and compares SEED against golden.
REQ-014 busy SHALL equal (state==COMPACT || state==COMPARE) and SHALL be low in IDLE and DONE.

Reset
REQ-015 With rst=1 at a clock edge, the block SHALL enter IDLE with signature=0, cnt=0, pass=0, done=0, busy=0 and latched registers=0.
REQ-016 rst SHALL take priority over start and din_valid.
REQ-017 rst during COMPACT or COMPARE SHALL abort the run, and no done pulse SHALL be produced.

Structure
REQ-018 A shared package misr_pkg SHALL hold the state enum and the defaults for WIDTH, POLY and SEED.
REQ-019 The MISR step and register SHALL be the sub-module misr_core (inputs: clk, rst, load, en, seed, din; output: sig). The FSM and compare logic SHALL remain in the top level.
REQ-020 The design SHALL have no latches and no combinational path from din to done or pass.

Verification
REQ-021 Single-word pass: start with test_len=1, golden=8'hE3, din=8'h00 valid one cycle -> signature=8'hE3, done pulses 2 cycles later, pass=1.
REQ-022 Two-word run with a stall: test_len=2, golden=8'hDB, din=8'h00 valid, one idle cycle, then 8'h00 valid -> signature holds 8'hE3 during the stall, ends at 8'hDB, pass=1.
REQ-023 Fail detect: same as REQ-022 but with golden=8'hDA -> done pulses, pass=0, signature=8'hDB.
REQ-024 Zero length: test_len=0, golden=8'hFF, start -> COMPARE next cycle, done one cycle later, pass=1, din ignored.
REQ-025 Reset mid-run: test_len=5, rst asserted after 3 valid words -> all outputs 0, no done pulse. A fresh start afterwards reproduces the REQ-021 result.
REQ-026 Ignored start: start pulsed during COMPACT with a different test_len -> the original run length and signature are unaffected.
